// File: rtl/rr_sel_4_if.sv
// rr_sel_4_if
//   Bundles the request/grant handshake between the requesters and the
//   round-robin select generator that steers the 4:1 mux.
//
//   Signals:
//     req    [3:0]  request per mux input (bit n requests i_n)
//     done          current owner releases its grant
//     s_0, s_1      registered mux select pair
//     gnt    [3:0]  one-hot grant, zero when idle
//     busy          a grant is active
//     expire        one-cycle pulse: the grant just ended by timeout
//
//   Modports:
//     master  requester side (drives req/done, observes grant outputs)
//     slave   arbiter side (rr_sel_4)
interface rr_sel_4_if;
  logic [3:0] req;
  logic       done;
  logic       s_0;
  logic       s_1;
  logic [3:0] gnt;
  logic       busy;
  logic       expire;

  modport master (output req, done, input s_0, s_1, gnt, busy, expire);
  modport slave  (input req, done, output s_0, s_1, gnt, busy, expire);
endinterface

// File: rtl/rr_sel_4.sv
// rr_sel_4
//   Round-robin select generator sitting directly upstream of a 4:1 mux.
//   Arbitrates four requests, drives the mux select pair so the granted
//   input reaches the mux output, and holds each grant until the owner
//   signals done, drops its request, or the hold limit runs out.
//
//   Parameters:
//     MAX_HOLD  maximum cycles one grant may last (1..255)
//
//   Ports:
//     clk   clock, all state changes on the rising edge
//     rst   synchronous active-high reset
//     bus   rr_sel_4_if.slave: req/done in; s_0/s_1/gnt/busy/expire out
module rr_sel_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  rr_sel_4_if.slave      bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic       expire_q, expire_d;

  logic [1:0] arb_start;
  logic       arb_found;
  logic [1:0] arb_idx;
  logic       rel_done, rel_drop, rel_time, release_now;

  // Cyclic search starting at k: rotate req so that bit k lands at
  // position 0, then take the lowest set bit and add k back.
  function automatic logic [1:0] arb_pick(input logic [3:0] r, input logic [1:0] k);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] idx;
    dbl = {r, r} >> k;
    rot = dbl[3:0];
    idx = k;
    for (int j = 3; j >= 0; j--) begin
      if (rot[j]) idx = k + 2'(j);
    end
    return idx;
  endfunction

  // While a grant is active the owner is sel_q; on release the search
  // starts just past it so the previous owner has lowest priority.
  assign arb_start = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
  assign arb_found = |bus.req;
  assign arb_idx   = arb_pick(bus.req, arb_start);

  assign rel_done    = bus.done;
  assign rel_drop    = ~bus.req[sel_q];
  assign rel_time    = (hcnt_q == HOLD_LAST);
  assign release_now = rel_done | rel_drop | rel_time;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    hcnt_d   = hcnt_q;
    gnt_d    = gnt_q;
    expire_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << arb_idx;
          sel_d   = arb_idx;
          hcnt_d  = 8'd0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d    = sel_q + 2'd1;
          // Timeout only reports when it is the sole reason for release.
          expire_d = rel_time & ~rel_done & ~rel_drop;
          if (arb_found) begin
            gnt_d  = 4'b0001 << arb_idx;
            sel_d  = arb_idx;
            hcnt_d = 8'd0;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      sel_q    <= 2'd0;
      hcnt_q   <= 8'd0;
      gnt_q    <= 4'b0000;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      hcnt_q   <= hcnt_d;
      gnt_q    <= gnt_d;
      expire_q <= expire_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.busy   = (state_q == GRANT);
  assign bus.s_0    = sel_q[0];
  assign bus.s_1    = sel_q[1];
  assign bus.expire = expire_q;

endmodule

// File: tb/tb_rr_sel_4.sv
// tb_rr_sel_4
//   Drives two rr_sel_4 instances (MAX_HOLD=8 and MAX_HOLD=1) with the
//   same request/done/reset stream and compares every output each cycle
//   against a behavioural model of the arbitration rules, plus a few
//   directed scenarios with hand-derived expected values.
module tb_rr_sel_4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   assertCount = 0;
  int   failCount   = 0;

  always #5 clk = ~clk;

  rr_sel_4_if bus8 ();
  rr_sel_4_if bus1 ();

  rr_sel_4 #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  rr_sel_4 #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Model state: who owns the grant, how many cycles it has lasted so far,
  // the rotating pointer and the expire pulse.
  typedef struct packed {
    logic       busy;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [8:0] held;
    logic       expire;
  } model_t;

  model_t m8 = '0;
  model_t m1 = '0;

  function automatic logic [1:0] pickWinner(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] w;
    bit found;
    w = 2'd0;
    found = 0;
    for (int j = 0; j < 4; j++) begin
      int c;
      c = (int'(start) + j) % 4;
      if (r[c] && !found) begin
        w = 2'(c);
        found = 1;
      end
    end
    return w;
  endfunction

  function automatic model_t modelStep(input model_t m, input logic rstV,
                                       input logic [3:0] r, input logic d, input int maxHold);
    model_t n;
    bit byDone, byDrop, byTime;
    n = m;
    n.expire = 1'b0;
    if (rstV) begin
      n = '0;
    end else if (!m.busy) begin
      if (r != 4'b0000) begin
        n.busy  = 1'b1;
        n.owner = pickWinner(r, m.ptr);
        n.held  = 9'd1;
      end
    end else begin
      byDone = d;
      byDrop = !r[m.owner];
      byTime = (int'(m.held) == maxHold);
      if (byDone || byDrop || byTime) begin
        n.expire = byTime && !byDone && !byDrop;
        n.ptr    = 2'((int'(m.owner) + 1) % 4);
        if (r != 4'b0000) begin
          n.owner = pickWinner(r, n.ptr);
          n.held  = 9'd1;
        end else begin
          n.busy = 1'b0;
        end
      end else begin
        n.held = m.held + 9'd1;
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareModels();
    checkOutput("h8_gnt",    32'(bus8.gnt),    m8.busy ? 32'(4'b0001 << m8.owner) : 32'd0);
    checkOutput("h8_busy",   32'(bus8.busy),   32'(m8.busy));
    checkOutput("h8_sel",    32'({bus8.s_1, bus8.s_0}), 32'(m8.owner));
    checkOutput("h8_expire", 32'(bus8.expire), 32'(m8.expire));
    checkOutput("h1_gnt",    32'(bus1.gnt),    m1.busy ? 32'(4'b0001 << m1.owner) : 32'd0);
    checkOutput("h1_busy",   32'(bus1.busy),   32'(m1.busy));
    checkOutput("h1_sel",    32'({bus1.s_1, bus1.s_0}), 32'(m1.owner));
    checkOutput("h1_expire", 32'(bus1.expire), 32'(m1.expire));
  endtask

  // One clock: drive inputs on the falling edge, advance the models over
  // the rising edge, then sample just after it.
  task automatic applyStimulus(input logic rstV, input logic [3:0] reqV, input logic doneV);
    @(negedge clk);
    rst       = rstV;
    bus8.req  = reqV;
    bus8.done = doneV;
    bus1.req  = reqV;
    bus1.done = doneV;
    m8 = modelStep(m8, rstV, reqV, doneV, 8);
    m1 = modelStep(m1, rstV, reqV, doneV, 1);
    @(posedge clk);
    #1;
    compareModels();
  endtask

  initial begin
    logic [3:0] rotSeq [5];
    logic [3:0] reqV;
    logic       doneV;
    logic       rstV;
    rotSeq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    bus8.req = 4'b0000; bus8.done = 1'b0;
    bus1.req = 4'b0000; bus1.done = 1'b0;

    // Reset, single requester, release with re-grant, then reset mid-grant.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("rst_gnt", 32'(bus8.gnt), 32'd0);
    applyStimulus(1'b0, 4'b0100, 1'b0);
    checkOutput("d1_gnt", 32'(bus8.gnt), 32'(4'b0100));
    checkOutput("d1_sel", 32'({bus8.s_1, bus8.s_0}), 32'd2);
    applyStimulus(1'b0, 4'b0100, 1'b1);
    applyStimulus(1'b1, 4'b0100, 1'b0);
    checkOutput("d1_rst_gnt",  32'(bus8.gnt),  32'd0);
    checkOutput("d1_rst_busy", 32'(bus8.busy), 32'd0);
    checkOutput("d1_rst_sel",  32'({bus8.s_1, bus8.s_0}), 32'd0);

    // All requesting with done every grant: rotation 0,1,2,3,0 from ptr=0.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkOutput("d2_rot_gnt", 32'(bus8.gnt), 32'(rotSeq[i]));
      checkOutput("d2_rot_exp", 32'(bus8.expire), 32'd0);
    end

    // Sole requester held past the hold limit.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'b0010, 1'b0);
      checkOutput("d3_hold_gnt", 32'(bus8.gnt), 32'(4'b0010));
      checkOutput("d3_hold_exp", 32'(bus8.expire), 32'd0);
    end
    applyStimulus(1'b0, 4'b0010, 1'b0);
    checkOutput("d3_expire", 32'(bus8.expire), 32'd1);
    checkOutput("d3_regrant", 32'(bus8.gnt), 32'(4'b0010));

    // Owner 3 times out together with done: next grant 0, no expire.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b1000, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 4'b1001, 1'b0);
    checkOutput("d4_owner3", 32'(bus8.gnt), 32'(4'b1000));
    applyStimulus(1'b0, 4'b1001, 1'b1);
    checkOutput("d4_gnt", 32'(bus8.gnt), 32'(4'b0001));
    checkOutput("d4_exp", 32'(bus8.expire), 32'd0);

    // Owner 1 drops with nobody else: idle with select held, then ptr=2.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0010, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("d5_idle_busy", 32'(bus8.busy), 32'd0);
    checkOutput("d5_idle_sel",  32'({bus8.s_1, bus8.s_0}), 32'd1);
    applyStimulus(1'b0, 4'b0011, 1'b0);
    checkOutput("d5_gnt", 32'(bus8.gnt), 32'(4'b0001));

    // MAX_HOLD=1 instance: alternating grants with expire every cycle.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 4'b0101, 1'b0);
      checkOutput("d6_gnt", 32'(bus1.gnt), (i % 2 == 0) ? 32'(4'b0001) : 32'(4'b0100));
      checkOutput("d6_exp", 32'(bus1.expire), (i == 0) ? 32'd0 : 32'd1);
    end

    // Randomized traffic with sticky requests, sporadic done and reset.
    reqV = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) reqV = 4'($urandom_range(0, 15));
      doneV = ($urandom_range(0, 4) == 0);
      rstV  = ($urandom_range(0, 99) == 0);
      applyStimulus(rstV, reqV, doneV);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
